// File: rtl/exponent_avalon_ctrl_if.sv
// rtl/exponent_avalon_ctrl_if.sv - Avalon-MM register bus plus exponent core handshake bundle
interface exponent_avalon_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [23:0]       address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              irq;
    logic              core_enable;
    logic [DATA_W-1:0] core_x;
    logic [DATA_W-1:0] core_a;
    logic              core_ready;
    logic [DATA_W-1:0] core_p;

    modport slave (
        input  address, write, writedata, read, core_ready, core_p,
        output readdata, irq, core_enable, core_x, core_a
    );

    modport master (
        output address, write, writedata, read, core_ready, core_p,
        input  readdata, irq, core_enable, core_x, core_a
    );
endinterface

// File: rtl/exponent_avalon_ctrl.sv
// rtl/exponent_avalon_ctrl.sv - register front-end and job sequencer for the exponent core
module exponent_avalon_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    exponent_avalon_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_LOW  = 2'd2;
    localparam logic [1:0] S_WAIT_HIGH = 2'd3;

    localparam logic [DATA_W-1:0] TIMEOUT_W = DATA_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] CYC_MAX   = {DATA_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              err_busy_q, err_busy_d;
    logic              err_to_q, err_to_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] cycles_q, cycles_d;
    logic [DATA_W-1:0] core_x_q, core_x_d;
    logic [DATA_W-1:0] core_a_q, core_a_d;
    logic              core_enable_q, core_enable_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;

    logic [2:0]        addr;
    logic              busy;
    logic              start_req;
    logic [DATA_W-1:0] status_w;
    logic              unused_addr_hi;

    assign addr           = bus.address[2:0];
    assign unused_addr_hi = ^bus.address[23:3];
    assign busy           = (state_q != S_IDLE);
    assign start_req      = bus.write && (addr == 3'd2) && bus.writedata[0];

    always_comb begin
        status_w      = '0;
        status_w[3:0] = {err_to_q, err_busy_q, done_q, busy};
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        exp_d         = exp_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        err_busy_d    = err_busy_q;
        err_to_d      = err_to_q;
        result_d      = result_q;
        cycles_d      = cycles_q;
        core_x_d      = core_x_q;
        core_a_d      = core_a_q;
        core_enable_d = 1'b0;
        readdata_d    = readdata_q;

        // Register writes land first so a clear_done is seen before any start or completion.
        if (bus.write) begin
            case (addr)
                3'd0: base_d = bus.writedata;
                3'd1: exp_d  = bus.writedata;
                3'd2: begin
                    irq_en_d = bus.writedata[2];
                    if (bus.writedata[1]) begin
                        done_d     = 1'b0;
                        err_busy_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (busy) begin
            if (cycles_q != CYC_MAX) cycles_d = cycles_q + 1'b1;
            if (start_req) err_busy_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    core_x_d = base_q;
                    core_a_d = exp_q;
                    done_d   = 1'b0;
                    err_to_d = 1'b0;
                    cycles_d = '0;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.core_ready) begin
                    core_enable_d = 1'b1;
                    state_d       = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!bus.core_ready) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (bus.core_ready) begin
                    result_d = bus.core_p;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog: a completion in the same cycle takes precedence over the abort.
        if (busy && (state_d != S_IDLE) && (cycles_d >= TIMEOUT_W)) begin
            err_to_d      = 1'b1;
            done_d        = 1'b1;
            core_enable_d = 1'b0;
            state_d       = S_IDLE;
        end

        if (bus.read) begin
            case (addr)
                3'd0:    readdata_d = base_q;
                3'd1:    readdata_d = exp_q;
                3'd2:    readdata_d = {{(DATA_W-3){1'b0}}, irq_en_q, 2'b00};
                3'd3:    readdata_d = status_w;
                3'd4:    readdata_d = result_q;
                3'd5:    readdata_d = cycles_q;
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            exp_q         <= '0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            err_busy_q    <= 1'b0;
            err_to_q      <= 1'b0;
            result_q      <= '0;
            cycles_q      <= '0;
            core_x_q      <= '0;
            core_a_q      <= '0;
            core_enable_q <= 1'b0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            exp_q         <= exp_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            err_busy_q    <= err_busy_d;
            err_to_q      <= err_to_d;
            result_q      <= result_d;
            cycles_q      <= cycles_d;
            core_x_q      <= core_x_d;
            core_a_q      <= core_a_d;
            core_enable_q <= core_enable_d;
            readdata_q    <= readdata_d;
        end
    end

    assign bus.readdata    = readdata_q;
    assign bus.irq         = done_q & irq_en_q;
    assign bus.core_enable = core_enable_q;
    assign bus.core_x      = core_x_q;
    assign bus.core_a      = core_a_q;
endmodule

// File: tb/tb_exponent_avalon_ctrl.sv
// tb/tb_exponent_avalon_ctrl.sv - directed self-checking bench for exponent_avalon_ctrl
module tb_exponent_avalon_ctrl;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    int          lat;
    int          cnt;
    logic        hang;
    logic [31:0] model_p;
    int          en_cnt;
    logic [31:0] en_x;
    logic [31:0] en_a;
    logic [31:0] rd;

    exponent_avalon_ctrl_if #(.DATA_W(32)) bus ();

    exponent_avalon_ctrl #(.DATA_W(32), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Core stand-in: drops ready the cycle after enable, raises it lat cycles later.
    always @(negedge clock) begin
        if (bus.core_enable) begin
            en_cnt         = en_cnt + 1;
            en_x           = bus.core_x;
            en_a           = bus.core_a;
            bus.core_ready = 1'b0;
            cnt            = lat;
        end else if (!bus.core_ready && !hang && cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                bus.core_ready = 1'b1;
                bus.core_p     = model_p;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clock);
        bus.write     = 1'b0;
    endtask

    task automatic rdreg(input logic [23:0] a, output logic [31:0] d);
        @(negedge clock);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clock);
        bus.read    = 1'b0;
        d           = bus.readdata;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        s = '0;
        for (int n = 0; n < 40; n++) begin
            rdreg(24'd3, s);
            if (s[1]) break;
        end
        check(tag, {31'b0, s[1]}, 32'd1);
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        lat            = 3;
        cnt            = 0;
        hang           = 1'b0;
        model_p        = '0;
        en_cnt         = 0;
        en_x           = '0;
        en_a           = '0;
        reset          = 1'b1;
        bus.address    = '0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.read       = 1'b0;
        bus.core_ready = 1'b1;
        bus.core_p     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_irq", {31'b0, bus.irq}, 32'd0);
        check("rst_enable", {31'b0, bus.core_enable}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            rdreg(24'(a), rd);
            check($sformatf("rst_read_%0d", a), rd, 32'd0);
        end

        // Job 1: 3^4 with a busy start and a BASE overwrite mid-flight
        lat     = 10;
        model_p = 32'd81;
        wr(24'd0, 32'd3);
        wr(24'd1, 32'd4);
        wr(24'd2, 32'h5);
        rdreg(24'd3, rd);
        check("status_running", rd, 32'h1);
        wr(24'd2, 32'h5);
        wr(24'd0, 32'd7);
        rdreg(24'd3, rd);
        check("status_err_busy", rd, 32'h5);
        check("core_x_held", bus.core_x, 32'd3);
        wait_done("job1_done");
        rdreg(24'd3, rd);
        check("job1_status", rd, 32'h6);
        rdreg(24'd4, rd);
        check("job1_result", rd, 32'd81);
        rdreg(24'd5, rd);
        check("job1_cycles", rd, 32'd12);
        check("job1_irq", {31'b0, bus.irq}, 32'd1);
        check("job1_enables", 32'(en_cnt), 32'd1);
        check("job1_core_x", en_x, 32'd3);
        check("job1_core_a", en_a, 32'd4);
        rdreg(24'd0, rd);
        check("base_rewritten", rd, 32'd7);
        rdreg(24'hABCD04, rd);
        check("addr_hi_ignored", rd, 32'd81);
        wr(24'd2, 32'h2);
        rdreg(24'd3, rd);
        check("clear_status", rd, 32'h0);
        check("clear_irq", {31'b0, bus.irq}, 32'd0);

        // Job 2: core never comes back, watchdog aborts
        hang = 1'b1;
        wr(24'd2, 32'h1);
        wait_done("timeout_done");
        rdreg(24'd3, rd);
        check("timeout_status", rd, 32'h0A);
        rdreg(24'd4, rd);
        check("timeout_result", rd, 32'd81);
        rdreg(24'd5, rd);
        check("timeout_cycles", rd, 32'd16);

        // Job 3: new start after abort, 5^3
        hang           = 1'b0;
        cnt            = 0;
        bus.core_ready = 1'b1;
        lat            = 3;
        model_p        = 32'd125;
        wr(24'd0, 32'd5);
        wr(24'd1, 32'd3);
        wr(24'd2, 32'h1);
        wait_done("job3_done");
        rdreg(24'd3, rd);
        check("job3_status", rd, 32'h2);
        rdreg(24'd4, rd);
        check("job3_result", rd, 32'd125);
        rdreg(24'd5, rd);
        check("job3_cycles", rd, 32'd5);

        // Job 4: clear_done lands on the completion cycle
        model_p = 32'd9;
        wr(24'd0, 32'd3);
        wr(24'd1, 32'd2);
        wr(24'd2, 32'h1);
        repeat (3) @(negedge clock);
        wr(24'd2, 32'h2);
        rdreg(24'd3, rd);
        check("race_status", rd, 32'h2);
        rdreg(24'd4, rd);
        check("race_result", rd, 32'd9);
        rdreg(24'd5, rd);
        check("race_cycles", rd, 32'd5);

        // Job 5: asynchronous reset while the core is computing
        lat     = 10;
        model_p = 32'd36;
        wr(24'd0, 32'd6);
        wr(24'd1, 32'd2);
        rdreg(24'd0, rd);
        check("pre_reset_read", rd, 32'd6);
        wr(24'd2, 32'h5);
        repeat (6) @(negedge clock);
        check("pre_reset_core_x", bus.core_x, 32'd6);
        reset = 1'b1;
        #1;
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_irq", {31'b0, bus.irq}, 32'd0);
        check("reset_enable", {31'b0, bus.core_enable}, 32'd0);
        check("reset_core_x", bus.core_x, 32'd0);
        check("reset_core_a", bus.core_a, 32'd0);
        @(negedge clock);
        reset          = 1'b0;
        cnt            = 0;
        bus.core_ready = 1'b1;
        rdreg(24'd3, rd);
        check("post_reset_status", rd, 32'h0);

        lat     = 3;
        model_p = 32'd1024;
        wr(24'd0, 32'd2);
        wr(24'd1, 32'd10);
        wr(24'd2, 32'h1);
        wait_done("job6_done");
        rdreg(24'd4, rd);
        check("job6_result", rd, 32'd1024);
        check("job6_core_x", en_x, 32'd2);
        check("job6_core_a", en_a, 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
